// File: rtl/lvds_ser_tx.sv
// lvds_ser_tx: parallel-to-serial transmitter driving a differential pair.
// Words are sent MSB first, one bit per clock. A new word may be accepted in
// the last bit cycle of the current one, so a stream held valid goes out
// with no idle gap. O and OB are both flops, so the pair switches on the
// same edge and never skews through a combinational inverter.
module lvds_ser_tx #(
    parameter int   WIDTH      = 8,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] D,
    input  logic             D_VALID,
    output logic             D_READY,
    output logic             O,
    output logic             OB,
    output logic             TX_BUSY
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] bit_cnt;
    logic [WIDTH-1:0] shreg;
    logic             accept;

    // Ready when idle or on the final bit of the current word; never in reset.
    always_comb begin
        // NOTE: every output of a combinational block gets a value on every
        // path; a missed branch would infer a latch.
        D_READY = RST_N && ((state == IDLE) || (bit_cnt == LAST_BIT));
        accept  = D_VALID && D_READY;
    end

    // FSM, bit counter, shift register and registered serial outputs.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!RST_N) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            O       <= IDLE_LEVEL;
            OB      <= ~IDLE_LEVEL;
            TX_BUSY <= 1'b0;
        end else if (accept) begin
            // The MSB goes straight to the output; the register keeps the
            // word so the following bits come from shreg[WIDTH-2] onward.
            state   <= SHIFT;
            bit_cnt <= '0;
            shreg   <= D;
            O       <= D[WIDTH-1];
            OB      <= ~D[WIDTH-1];
            TX_BUSY <= 1'b1;
        end else if (state == SHIFT) begin
            if (bit_cnt != LAST_BIT) begin
                bit_cnt <= bit_cnt + 1'b1;
                shreg   <= shreg << 1;
                O       <= shreg[WIDTH-2];
                OB      <= ~shreg[WIDTH-2];
            end else begin
                // Last bit has been on the line and nothing new arrived.
                state   <= IDLE;
                bit_cnt <= '0;
                shreg   <= '0;
                O       <= IDLE_LEVEL;
                OB      <= ~IDLE_LEVEL;
                TX_BUSY <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_lvds_ser_tx.sv
// Testbench for lvds_ser_tx. Two instances share one stimulus stream, one
// idling low and one idling high. The reference model is a queue of pending
// serial bits: an accepted word appends its bits MSB first, every clock pops
// one bit onto the line, and the line idles when the queue is empty.
module tb_lvds_ser_tx;

    localparam int W = 8;

    logic         CLK = 1'b0;
    logic         RST_N = 1'b0;
    logic         D_VALID = 1'b0;
    logic [W-1:0] D = '0;

    logic rdy0, o0, ob0, busy0;
    logic rdy1, o1, ob1, busy1;

    int vectors = 0;
    int miscompares = 0;

    bit q[$];

    always #5 CLK = ~CLK;

    lvds_ser_tx #(.WIDTH(W), .IDLE_LEVEL(1'b0)) dut0 (
        .CLK(CLK), .RST_N(RST_N), .D(D), .D_VALID(D_VALID),
        .D_READY(rdy0), .O(o0), .OB(ob0), .TX_BUSY(busy0)
    );

    lvds_ser_tx #(.WIDTH(W), .IDLE_LEVEL(1'b1)) dut1 (
        .CLK(CLK), .RST_N(RST_N), .D(D), .D_VALID(D_VALID),
        .D_READY(rdy1), .O(o1), .OB(ob1), .TX_BUSY(busy1)
    );

    // One clock: drive inputs at the falling edge, check ready, clock the
    // model on the rising edge, then check the outputs at the next falling edge.
    task automatic cycle(input logic rst, input logic vld, input logic [W-1:0] d,
                         output logic acc, output logic obs);
        logic exp_rdy, exp_busy, exp_bit, exp_o0, exp_o1;
        RST_N = rst;
        D_VALID = vld;
        D = d;
        #1;
        exp_rdy = rst && (q.size() == 0);
        vectors++;
        if (rdy0 !== exp_rdy) begin
            miscompares++;
            $display("FAIL ready0 t=%0t got=%b want=%b", $time, rdy0, exp_rdy);
        end
        vectors++;
        if (rdy1 !== exp_rdy) begin
            miscompares++;
            $display("FAIL ready1 t=%0t got=%b want=%b", $time, rdy1, exp_rdy);
        end
        acc = vld && exp_rdy;
        @(posedge CLK);
        if (!rst) begin
            q.delete();
        end else if (acc) begin
            for (int i = W - 1; i >= 0; i--) q.push_back(d[i]);
        end
        if (rst && q.size() > 0) begin
            exp_busy = 1'b1;
            exp_bit  = q.pop_front();
        end else begin
            exp_busy = 1'b0;
            exp_bit  = 1'b0;
        end
        exp_o0 = exp_busy ? exp_bit : 1'b0;
        exp_o1 = exp_busy ? exp_bit : 1'b1;
        @(negedge CLK);
        vectors++;
        if (o0 !== exp_o0 || ob0 !== ~exp_o0) begin
            miscompares++;
            $display("FAIL line0 t=%0t got O=%b OB=%b want O=%b OB=%b",
                     $time, o0, ob0, exp_o0, ~exp_o0);
        end
        vectors++;
        if (o1 !== exp_o1 || ob1 !== ~exp_o1) begin
            miscompares++;
            $display("FAIL line1 t=%0t got O=%b OB=%b want O=%b OB=%b",
                     $time, o1, ob1, exp_o1, ~exp_o1);
        end
        vectors++;
        if (busy0 !== exp_busy || busy1 !== exp_busy) begin
            miscompares++;
            $display("FAIL busy t=%0t got=%b/%b want=%b", $time, busy0, busy1, exp_busy);
        end
        obs = o0;
    endtask

    task automatic test_reset();
        logic acc, obs;
        cycle(1'b0, 1'b0, '0, acc, obs);
        cycle(1'b0, 1'b1, 8'h5A, acc, obs);
        vectors++;
        if (o0 !== 1'b0 || ob0 !== 1'b1 || busy0 !== 1'b0 || o1 !== 1'b1 || ob1 !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state got O0=%b OB0=%b BUSY0=%b O1=%b OB1=%b want 0 1 0 1 0",
                     o0, ob0, busy0, o1, ob1);
        end
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 1'b0, W'($urandom), acc, obs);
            vectors++;
            if (rdy0 !== 1'b1 || o0 !== 1'b0 || ob0 !== 1'b1 || busy0 !== 1'b0) begin
                miscompares++;
                $display("FAIL idle_hold cycle=%0d got RDY=%b O=%b OB=%b BUSY=%b want 1 0 1 0",
                         i, rdy0, o0, ob0, busy0);
            end
        end
    endtask

    task automatic test_single();
        logic acc, obs;
        logic [W-1:0] seq = '0;
        cycle(1'b1, 1'b1, 8'hA5, acc, obs);
        seq = {seq[W-2:0], obs};
        vectors++;
        if (acc !== 1'b1) begin
            miscompares++;
            $display("FAIL single_accept got=%b want=1", acc);
        end
        for (int i = 1; i < W; i++) begin
            cycle(1'b1, 1'b0, W'($urandom), acc, obs);
            seq = {seq[W-2:0], obs};
        end
        vectors++;
        if (seq !== 8'hA5) begin
            miscompares++;
            $display("FAIL single_seq got=%h want=a5", seq);
        end
        cycle(1'b1, 1'b0, '0, acc, obs);
        vectors++;
        if (obs !== 1'b0 || busy0 !== 1'b0) begin
            miscompares++;
            $display("FAIL single_end got O=%b BUSY=%b want 0 0", obs, busy0);
        end
    endtask

    task automatic test_back_to_back();
        logic acc, obs;
        logic [W-1:0] words [2];
        logic [2*W-1:0] seq = '0;
        int idx = 0;
        int busy_run = 0;
        int max_run = 0;
        words[0] = 8'hFF;
        words[1] = 8'h00;
        for (int i = 0; i < 22; i++) begin
            if (idx < 2) cycle(1'b1, 1'b1, words[idx], acc, obs);
            else         cycle(1'b1, 1'b0, '0, acc, obs);
            if (acc) idx++;
            if (busy0 === 1'b1) begin
                busy_run++;
                seq = {seq[2*W-2:0], obs};
            end else begin
                busy_run = 0;
            end
            if (busy_run > max_run) max_run = busy_run;
        end
        vectors++;
        if (max_run != 2 * W || seq !== 16'hFF00) begin
            miscompares++;
            $display("FAIL back_to_back got run=%0d bits=%h want run=16 bits=ff00", max_run, seq);
        end
    endtask

    task automatic test_reset_mid();
        logic acc, obs;
        int busy_seen = 0;
        cycle(1'b1, 1'b1, 8'hC3, acc, obs);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, '0, acc, obs);
        cycle(1'b0, 1'b0, '0, acc, obs);
        vectors++;
        if (o0 !== 1'b0 || ob0 !== 1'b1 || busy0 !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset got O=%b OB=%b BUSY=%b want 0 1 0", o0, ob0, busy0);
        end
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 1'b0, '0, acc, obs);
            if (busy0 !== 1'b0 || obs !== 1'b0) busy_seen++;
        end
        vectors++;
        if (busy_seen != 0) begin
            miscompares++;
            $display("FAIL mid_reset_abort got %0d data cycles want 0", busy_seen);
        end
    endtask

    task automatic test_d_change();
        logic acc, obs;
        logic [W-1:0] seq = '0;
        cycle(1'b1, 1'b1, 8'h3C, acc, obs);
        seq = {seq[W-2:0], obs};
        for (int i = 1; i < W; i++) begin
            cycle(1'b1, 1'b0, W'($urandom), acc, obs);
            seq = {seq[W-2:0], obs};
        end
        vectors++;
        if (seq !== 8'h3C) begin
            miscompares++;
            $display("FAIL d_change got=%h want=3c", seq);
        end
        cycle(1'b1, 1'b0, '0, acc, obs);
    endtask

    task automatic test_random();
        logic acc, obs;
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom % 60) != 0, ($urandom % 4) != 0, W'($urandom), acc, obs);
        end
        for (int i = 0; i < W + 2; i++) cycle(1'b1, 1'b0, '0, acc, obs);
    endtask

    initial begin
        @(negedge CLK);
        test_reset();
        test_single();
        test_back_to_back();
        test_reset_mid();
        test_d_change();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
